// File: rtl/rshift_seq_if.sv
// Handshake and data bundle between the control unit (master) and the
// multi-cycle right shifter (slave).
interface rshift_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   b;

    modport master (
        output start, a, shamt, arith,
        input  busy, done, b
    );

    modport slave (
        input  start, a, shamt, arith,
        output busy, done, b
    );
endinterface

// File: rtl/rshift_seq.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV): one bit per clock under a
// start/busy/done handshake; b holds the last result until the next one lands.
module rshift_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    rshift_seq_if.slave io
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] cnt;
    logic               arith_q;
    logic [WIDTH-1:0]   shifted;

    // Fill bit comes from the latched operand's MSB, so live inputs never leak in.
    assign shifted = {arith_q ? data[WIDTH-1] : 1'b0, data[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data    <= '0;
            cnt     <= '0;
            arith_q <= 1'b0;
            io.b    <= '0;
            io.busy <= 1'b0;
            io.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (io.start) begin
                        data    <= io.a;
                        arith_q <= io.arith;
                        cnt     <= io.shamt;
                        if (io.shamt == '0) begin
                            io.b    <= io.a;
                            state   <= DONE;
                            io.busy <= 1'b0;
                            io.done <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            io.busy <= 1'b1;
                            io.done <= 1'b0;
                        end
                    end else begin
                        state   <= IDLE;
                        io.busy <= 1'b0;
                        io.done <= 1'b0;
                    end
                end
                SHIFT: begin
                    // start is ignored here; no request is queued.
                    data <= shifted;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        io.b    <= shifted;
                        state   <= DONE;
                        io.busy <= 1'b0;
                        io.done <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    io.busy <= 1'b0;
                    io.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rshift_seq.sv
// Directed plus randomized bench for rshift_seq, checked against a plain
// arithmetic model of logical/arithmetic right shift.
module tb_rshift_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rshift_seq_if #(.WIDTH(32), .SHAMT_W(5)) io ();

    rshift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] av, input int sh, input logic ar);
        logic [63:0] ext;
        ext = {(ar && av[31]) ? 32'hFFFF_FFFF : 32'h0, av};
        ext = ext >> sh;
        return ext[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents a request, scrambles operands after the
    // accept edge, and returns at the negedge where done is high.
    task automatic do_op(input logic [31:0] av, input int sh, input logic ar, input string tag);
        logic [31:0] exp, prevb;
        int cyc, bc;
        logic stable;
        exp    = ref_shift(av, sh, ar);
        prevb  = io.b;
        stable = 1'b1;
        io.start = 1'b1; io.a = av; io.shamt = 5'(sh); io.arith = ar;
        @(negedge clk);
        io.start = 1'b0; io.a = $urandom; io.shamt = 5'($urandom); io.arith = 1'($urandom);
        cyc = 1; bc = 0;
        while (!io.done && cyc < 40) begin
            if (io.busy) bc++;
            if (io.b !== prevb) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".done"}, 32'(io.done), 32'd1);
        check({tag, ".lat"}, 32'(cyc), 32'(sh + 1));
        check({tag, ".busycyc"}, 32'(bc), 32'(sh));
        check({tag, ".b"}, io.b, exp);
        check({tag, ".bhold"}, 32'(stable), 32'd1);
    endtask

    task automatic after_op(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check({tag, ".pulse"}, 32'(io.done), 32'd0);
        check({tag, ".bkeep"}, io.b, exp);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra;
        int rs;
        logic rar;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        io.start = 1'b0; io.a = '0; io.shamt = '0; io.arith = 1'b0;
        #1;
        check("rst.busy", 32'(io.busy), 32'd0);
        check("rst.done", 32'(io.done), 32'd0);
        check("rst.b", io.b, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h8000_0000, 4, 1'b0, "srl4");      after_op("srl4", 32'h0800_0000);
        do_op(32'h8000_0000, 4, 1'b1, "sra4n");     after_op("sra4n", 32'hF800_0000);
        do_op(32'h7FFF_FFF0, 4, 1'b1, "sra4p");     after_op("sra4p", 32'h07FF_FFFF);
        do_op(32'hDEAD_BEEF, 0, 1'b0, "zero_l");    after_op("zero_l", 32'hDEAD_BEEF);
        do_op(32'hDEAD_BEEF, 0, 1'b1, "zero_a");    after_op("zero_a", 32'hDEAD_BEEF);
        do_op(32'h8000_0001, 31, 1'b0, "srl31");    after_op("srl31", 32'h0000_0001);
        do_op(32'h8000_0001, 31, 1'b1, "sra31");    after_op("sra31", 32'hFFFF_FFFF);

        // Start during SHIFT must be dropped.
        io.start = 1'b1; io.a = 32'h100; io.shamt = 5'd8; io.arith = 1'b0;
        @(negedge clk);
        io.start = 1'b0;
        repeat (3) @(negedge clk);
        io.start = 1'b1; io.a = 32'hFFFF_FFFF; io.shamt = 5'd1; io.arith = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        pulses = 0;
        repeat (20) begin
            if (io.done) pulses++;
            @(negedge clk);
        end
        check("busy_start.pulses", 32'(pulses), 32'd1);
        check("busy_start.b", io.b, 32'h0000_0001);

        // Asynchronous reset mid-SHIFT.
        io.start = 1'b1; io.a = 32'hFFFF_0000; io.shamt = 5'd10; io.arith = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(io.busy), 32'd0);
        check("midrst.done", 32'(io.done), 32'd0);
        check("midrst.b", io.b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (io.done) pulses++;
        end
        check("midrst.nopulse", 32'(pulses), 32'd0);
        check("midrst.bzero", io.b, 32'd0);

        // Back-to-back: new request issued in the DONE cycle.
        do_op(32'h80, 3, 1'b0, "b2b_first");
        do_op(32'h1000, 2, 1'b0, "b2b_second");
        after_op("b2b_second", 32'h0000_0400);

        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            rs  = int'($urandom_range(31, 0));
            rar = 1'($urandom);
            if (i % 3 == 0) ra[31] = 1'b1;
            do_op(ra, rs, rar, "rand");
            after_op("rand", ref_shift(ra, rs, rar));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
